seq_shift_add_multiplier: RTL

- Iterative, parametrised multiplier: WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit retired per cycle.
- Next generation after the fixed 4-bit combinational Kogge-Stone adder. Its internal accumulate step is a WIDTH+1-bit parallel-prefix (Kogge-Stone) adder.
- Sits between operand staging and result writeback in the 32-bit multiplier datapath.
- Valid/ready on both sides, so it can stall against downstream.

---
 rtl/seq_shift_add_multiplier.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: iterative WIDTH x WIDTH -> 2*WIDTH shift-add
// multiplier retiring one multiplier bit per cycle. The accumulate step uses
// a WIDTH+1-bit Kogge-Stone parallel-prefix adder. Valid/ready on both sides.
// Optional feature: define MUL_SIGNED_EN to add the signed_mode port
// (sign-magnitude handling around the unsigned core).
module seq_shift_add_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
`ifdef MUL_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int LVL = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     acc;
    logic [CNT_W-1:0]     count;
`ifdef MUL_SIGNED_EN
    logic                 neg;
`endif

    logic [WIDTH-1:0]     op0;
    logic [WIDTH-1:0]     op1;
    logic                 op_neg;
    logic [WIDTH:0]       ks_a;
    logic [WIDTH:0]       ks_b;
    logic [WIDTH:0]       ks_sum;
    logic [WIDTH:0]       g;
    logic [WIDTH:0]       p;
    logic [WIDTH:0]       gn;
    logic [WIDTH:0]       pn;
    logic [WIDTH:0]       p0;
    logic [2*WIDTH-1:0]   next_prod;
    logic [2*WIDTH-1:0]   prod_fin;

    // Operand conditioning at accept: magnitudes plus product sign when signed
    always_comb begin
        op0    = in0;
        op1    = in1;
        op_neg = 1'b0;
`ifdef MUL_SIGNED_EN
        if (signed_mode) begin
            if (in0[WIDTH-1]) op0 = ~in0 + 1'b1;
            if (in1[WIDTH-1]) op1 = ~in1 + 1'b1;
            op_neg = in0[WIDTH-1] ^ in1[WIDTH-1];
        end
`endif
    end

    // Kogge-Stone accumulate of the conditional multiplicand, then the shifted step
    always_comb begin
        ks_a = {1'b0, acc};
        ks_b = mplier[0] ? {1'b0, mcand} : '0;
        g    = ks_a & ks_b;
        p    = ks_a ^ ks_b;
        p0   = p;
        gn   = '0;
        pn   = '0;
        for (int unsigned l = 0; l < LVL; l++) begin
            gn = g;
            pn = p;
            for (int unsigned i = (1 << l); i <= WIDTH; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        ks_sum[0] = p0[0];
        for (int unsigned i = 1; i <= WIDTH; i++) begin
            ks_sum[i] = p0[i] ^ g[i-1];
        end
        // {acc, mplier} after add-then-shift-right: sum drops into the top,
        // its LSB moves into the vacated multiplier MSB
        next_prod = {ks_sum, mplier[WIDTH-1:1]};
    end

    // Final product, negated on the last step when the operand signs differed
    always_comb begin
        prod_fin = next_prod;
`ifdef MUL_SIGNED_EN
        if (neg) prod_fin = ~next_prod + 1'b1;
`endif
    end

    // Control FSM and datapath registers, all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
`ifdef MUL_SIGNED_EN
            neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= op0;
                        mplier   <= op1;
                        acc      <= '0;
                        count    <= '0;
`ifdef MUL_SIGNED_EN
                        neg      <= op_neg;
`endif
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    acc    <= next_prod[2*WIDTH-1:WIDTH];
                    mplier <= next_prod[WIDTH-1:0];
                    count  <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= prod_fin;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MUL_SIGNED_EN
    // op_neg only feeds the signed path; keep it referenced in the unsigned build
    logic unused_neg;
    assign unused_neg = op_neg;
`endif

endmodule
